pixel_render_scheduler: RTL and testbench
=========================================

Name: pixel_render_scheduler

Overview:
- Sequences the per-pixel ray/block intersection engine (block selector plus intersect unit) across one frame.
- Rasterises X/Y in row-major order and issues one pixel at a time, then waits for that pixel's result before issuing the next.
- Freezes frame time and the block-set snapshot at frame start.
- Applies downstream backpressure, and flags timeouts, stale results and frame overruns.

Parameters:
- H_PIXELS, 1024, pixels per row; x range 0..H_PIXELS-1.
- V_PIXELS, 768, rows per frame; y range 0..V_PIXELS-1.
- TIMEOUT, 63, maximum WAIT cycles before a pixel is abandoned. Must be ≥ 16; the engine needs 13+ cycles per pixel.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- frame_start_in  input  1  one-cycle pulse requesting a new frame.
- curr_time_in  input  18  running game time.
- out_ready_in  input  1  downstream (framebuffer writer) can accept a pixel result.
- eng_valid_in  input  1  engine result valid (one-cycle pulse).
- eng_x_in  input  11  x echoed by the engine with its result.
- eng_y_in  input  10  y echoed by the engine with its result.
- pix_x_out  output  11  pixel x presented to the engine.
- pix_y_out  output  10  pixel y presented to the engine.
- pix_valid_out  output  1  one-cycle issue strobe for pix_x_out/pix_y_out.
- frame_time_out  output  18  curr_time_in captured at frame start, held for the whole frame.
- snapshot_latch_out  output  1  one-cycle pulse telling the block tracker to freeze its 12-block set.
- result_accept_out  output  1  one-cycle pulse when a matching engine result is accepted.
- busy_out  output  1  high from LATCH through DONE.
- frame_done_out  output  1  one-cycle pulse after the last pixel is accepted.
- timeout_err_out  output  1  sticky: a pixel timed out.
- overrun_err_out  output  1  sticky: frame_start_in arrived while busy.
- stale_cnt_out  output  8  count of ignored non-matching results; saturates at 255.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - State IDLE.
  - pix_x_out=0, pix_y_out=0, frame_time_out=0, stale_cnt_out=0.
  - All 1-bit outputs 0.
  - Wait counter 0.
- IDLE:
  - On frame_start_in=1: capture frame_time_out<=curr_time_in, clear x/y to 0, go to LATCH.
  - Otherwise remain in IDLE.
- LATCH (1 cycle): snapshot_latch_out=1, busy_out=1; go to ISSUE.
- ISSUE:
  - If out_ready_in=1: pix_valid_out=1 for this cycle with the current x/y, clear the wait counter, go to WAIT.
  - If out_ready_in=0: stall in ISSUE with no strobe.
- WAIT:
  - Wait counter increments each cycle.
  - If eng_valid_in=1 and eng_x_in/eng_y_in equal the issued x/y: result_accept_out=1, go to ADVANCE.
  - If eng_valid_in=1 with non-matching x/y: the result is stale. Increment stale_cnt_out (saturating) and stay in WAIT.
  - If the counter reaches TIMEOUT with no match: set timeout_err_out, go to ADVANCE with no accept.
- ADVANCE (1 cycle):
  - If x<H_PIXELS-1: x<=x+1.
  - Else: x<=0, y<=y+1.
  - If the pixel just finished was (H_PIXELS-1, V_PIXELS-1): go to DONE.
  - Otherwise go to ISSUE.
- DONE (1 cycle): frame_done_out=1, busy_out still 1; go to IDLE.
  - frame_start_in is sampled again in IDLE, so a new frame cannot begin earlier than the cycle after DONE.
- Overrun:
  - frame_start_in=1 in any state other than IDLE sets overrun_err_out (sticky).
  - The current frame continues unaffected; the request is dropped.
- Same-cycle accept and timeout: a matching eng_valid_in wins over timeout.
- Sticky errors and stale_cnt_out clear only on reset. They do not clear at a new frame.
- pix_x_out/pix_y_out hold their value outside ISSUE; the engine samples them only on pix_valid_out.
- Per-pixel latency from issue strobe to ADVANCE = engine latency + 1 cycle.
- Minimum cycles per frame = 2 + H_PIXELS*V_PIXELS*(engine latency + 3), counting the ISSUE, WAIT-accept and ADVANCE cycles per pixel.
- Reset asserted mid-frame: immediate return to IDLE. No frame_done_out is generated.

Test Plan (bench overrides: H_PIXELS=4, V_PIXELS=3, TIMEOUT=16; model engine echoes x/y 14 cycles after the strobe):
1. Reset, then a frame_start_in pulse with curr_time_in=0x12345.
   - Expect one snapshot_latch_out pulse.
   - Expect 12 strobes in order (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2), and 12 result_accept_out pulses.
   - Expect frame_done_out exactly once, frame_time_out=0x12345 for the whole frame, and busy_out falling the cycle after DONE.
2. Hold out_ready_in=0 for 20 cycles while in ISSUE at pixel (2,1).
   - Expect no strobe during the hold, then exactly one strobe for (2,1) after release; no pixel skipped or duplicated.
3. Model drops the result for (1,0).
   - Expect timeout_err_out=1 at WAIT count 16, advance to (2,0), frame still completes with 11 accepts.
4. Model returns echo (0,2) while (3,1) is outstanding, then the correct echo.
   - Expect stale_cnt_out=1, no accept for the stale result, accept on the correct one.
5. frame_start_in pulse mid-frame.
   - Expect overrun_err_out=1 and the frame completes normally.
   - Pulse again after DONE: a new frame starts, and overrun_err_out remains 1.
6. Deassert rst_in during WAIT at pixel (2,2).
   - Expect all outputs back to reset values asynchronously with no frame_done_out.
   - Expect a clean frame afterwards.

Source files
------------

// File: rtl/pixel_render_scheduler.sv
// Pixel render scheduler: walks one frame in row-major order, issues each pixel to the
// intersection engine, and waits for the engine to echo that pixel back before moving on.
module pixel_render_scheduler #(
   parameter int H_PIXELS = 1024,
   parameter int V_PIXELS = 768,
   parameter int TIMEOUT  = 63
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        frame_start_in,
   input  logic [17:0] curr_time_in,
   input  logic        out_ready_in,
   input  logic        eng_valid_in,
   input  logic [10:0] eng_x_in,
   input  logic [9:0]  eng_y_in,
   output logic [10:0] pix_x_out,
   output logic [9:0]  pix_y_out,
   output logic        pix_valid_out,
   output logic [17:0] frame_time_out,
   output logic        snapshot_latch_out,
   output logic        result_accept_out,
   output logic        busy_out,
   output logic        frame_done_out,
   output logic        timeout_err_out,
   output logic        overrun_err_out,
   output logic [7:0]  stale_cnt_out
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LATCH   = 3'd1;
   localparam logic [2:0] S_ISSUE   = 3'd2;
   localparam logic [2:0] S_WAIT    = 3'd3;
   localparam logic [2:0] S_ADVANCE = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [10:0]      X_LAST   = 11'(H_PIXELS - 1);
   localparam logic [9:0]       Y_LAST   = 10'(V_PIXELS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hFF) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

   logic [2:0]       state_q, state_d;
   logic [10:0]      x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [17:0]      frame_time_q, frame_time_d;
   logic [7:0]       stale_cnt_q, stale_cnt_d;
   logic             pix_valid_q, pix_valid_d;
   logic             snap_q, snap_d;
   logic             accept_q, accept_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             timeout_err_q, timeout_err_d;
   logic             overrun_err_q, overrun_err_d;
   logic             eng_match_s;
   logic             last_pixel_s;

   assign eng_match_s  = eng_valid_in && (eng_x_in == x_q) && (eng_y_in == y_q);
   assign last_pixel_s = (x_q == X_LAST) && (y_q == Y_LAST);

   // Next-state and next-output computation for the frame sequencer.
   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      cnt_d         = cnt_q;
      frame_time_d  = frame_time_q;
      stale_cnt_d   = stale_cnt_q;
      pix_valid_d   = 1'b0;
      snap_d        = 1'b0;
      accept_d      = 1'b0;
      done_d        = 1'b0;
      timeout_err_d = timeout_err_q;

      // A start request outside IDLE is dropped but remembered as an overrun.
      if (frame_start_in && (state_q != S_IDLE)) begin
         overrun_err_d = 1'b1;
      end else begin
         overrun_err_d = overrun_err_q;
      end

      case (state_q)
         S_IDLE: begin
            if (frame_start_in) begin
               frame_time_d = curr_time_in;
               x_d          = 11'd0;
               y_d          = 10'd0;
               snap_d       = 1'b1;
               state_d      = S_LATCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LATCH: begin
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (out_ready_in) begin
               pix_valid_d = 1'b1;
               cnt_d       = {CNT_W{1'b0}};
               state_d     = S_WAIT;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_ONE;
            if (eng_valid_in && !eng_match_s) begin
               stale_cnt_d = sat_inc8(stale_cnt_q);
            end else begin
               stale_cnt_d = stale_cnt_q;
            end
            // A matching result on the final wait cycle still counts as accepted.
            if (eng_match_s) begin
               accept_d = 1'b1;
               state_d  = S_ADVANCE;
            end else if (cnt_q == CNT_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = S_ADVANCE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_ADVANCE: begin
            if (x_q < X_LAST) begin
               x_d = x_q + 11'd1;
            end else begin
               x_d = 11'd0;
               y_d = y_q + 10'd1;
            end
            if (last_pixel_s) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State, pixel position, counters and registered outputs.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q       <= S_IDLE;
         x_q           <= 11'd0;
         y_q           <= 10'd0;
         cnt_q         <= {CNT_W{1'b0}};
         frame_time_q  <= 18'd0;
         stale_cnt_q   <= 8'd0;
         pix_valid_q   <= 1'b0;
         snap_q        <= 1'b0;
         accept_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         cnt_q         <= cnt_d;
         frame_time_q  <= frame_time_d;
         stale_cnt_q   <= stale_cnt_d;
         pix_valid_q   <= pix_valid_d;
         snap_q        <= snap_d;
         accept_q      <= accept_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

   assign pix_x_out          = x_q;
   assign pix_y_out          = y_q;
   assign pix_valid_out      = pix_valid_q;
   assign frame_time_out     = frame_time_q;
   assign snapshot_latch_out = snap_q;
   assign result_accept_out  = accept_q;
   assign busy_out           = busy_q;
   assign frame_done_out     = done_q;
   assign timeout_err_out    = timeout_err_q;
   assign overrun_err_out    = overrun_err_q;
   assign stale_cnt_out      = stale_cnt_q;

endmodule

// File: tb/tb_pixel_render_scheduler.sv
// Bench for pixel_render_scheduler on a 4x3 frame: an event-level model of the frame
// (pixel index, engine echo schedule, sticky flags) is compared against the DUT every cycle.
module tb_pixel_render_scheduler;

   localparam int H    = 4;
   localparam int V    = 3;
   localparam int TO   = 16;
   localparam int NPIX = H * V;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        frame_start_in;
   logic [17:0] curr_time_in;
   logic        out_ready_in;
   logic        eng_valid_in;
   logic [10:0] eng_x_in;
   logic [9:0]  eng_y_in;
   logic [10:0] pix_x_out;
   logic [9:0]  pix_y_out;
   logic        pix_valid_out;
   logic [17:0] frame_time_out;
   logic        snapshot_latch_out;
   logic        result_accept_out;
   logic        busy_out;
   logic        frame_done_out;
   logic        timeout_err_out;
   logic        overrun_err_out;
   logic [7:0]  stale_cnt_out;

   always #5 clk_in = ~clk_in;

   pixel_render_scheduler #(.H_PIXELS(H), .V_PIXELS(V), .TIMEOUT(TO)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
      .curr_time_in(curr_time_in), .out_ready_in(out_ready_in),
      .eng_valid_in(eng_valid_in), .eng_x_in(eng_x_in), .eng_y_in(eng_y_in),
      .pix_x_out(pix_x_out), .pix_y_out(pix_y_out), .pix_valid_out(pix_valid_out),
      .frame_time_out(frame_time_out), .snapshot_latch_out(snapshot_latch_out),
      .result_accept_out(result_accept_out), .busy_out(busy_out),
      .frame_done_out(frame_done_out), .timeout_err_out(timeout_err_out),
      .overrun_err_out(overrun_err_out), .stale_cnt_out(stale_cnt_out)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Model of the frame in terms of events on absolute cycle numbers (-1 = none pending).
   bit          m_active, m_timeout, m_overrun, m_issue_open;
   int          m_idx, m_drops, m_stale, m_issue_from;
   logic [17:0] m_ftime;
   int          m_echo_cyc, m_acc_at, m_to_at, m_done_at, m_idle_at;
   int          m_stale_cyc, m_stale_inc_at;
   int          m_cur_x, m_cur_y, m_stale_x, m_stale_y;

   // Scenario knobs and DUT-side per-frame tallies.
   int sc_drop_idx, sc_stale_idx;
   bit sc_random;
   int dut_acc, dut_strobes, dut_latch_cyc, last_len, last_acc, last_strobes;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_timeout = 0; m_overrun = 0; m_issue_open = 0;
      m_idx = 0; m_drops = 0; m_stale = 0; m_issue_from = -1; m_ftime = 18'd0;
      m_echo_cyc = -1; m_acc_at = -1; m_to_at = -1; m_done_at = -1; m_idle_at = -1;
      m_stale_cyc = -1; m_stale_inc_at = -1;
      eng_valid_in = 1'b0; eng_x_in = 11'd0; eng_y_in = 10'd0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_pix_x"}, int'(pix_x_out), 0);
      chk({tag, "_pix_y"}, int'(pix_y_out), 0);
      chk({tag, "_frame_time"}, int'(frame_time_out), 0);
      chk({tag, "_stale_cnt"}, int'(stale_cnt_out), 0);
      chk({tag, "_onebit"}, int'({pix_valid_out, snapshot_latch_out, result_accept_out, busy_out,
                                  frame_done_out, timeout_err_out, overrun_err_out}), 0);
   endtask

   // A pixel's fate is settled (accept or timeout) on cycle cyc; the next issue window opens.
   task automatic resolve();
      if (m_idx < NPIX) begin
         m_issue_open = 1;
         m_issue_from = cyc + 1;
      end else begin
         m_done_at = cyc + 1;
      end
   endtask

   task automatic observe();
      bit exp_snap, exp_strobe, exp_acc, exp_done, drop;
      int lat;
      cyc++;
      if (!rst_in) begin
         check_reset_vals("in_reset");
         return;
      end
      exp_snap = 0; exp_acc = 0; exp_done = 0;
      if (frame_start_in) begin
         if (m_active) begin
            m_overrun = 1;
         end else begin
            m_active = 1; exp_snap = 1; m_ftime = curr_time_in;
            m_idx = 0; m_drops = 0; m_issue_open = 1; m_issue_from = cyc + 1;
         end
      end
      if (cyc == m_idle_at) begin m_active = 0; m_idle_at = -1; end
      if (cyc == m_stale_inc_at) begin
         if (m_stale < 255) m_stale++;
         m_stale_inc_at = -1;
      end
      if (cyc == m_acc_at) begin exp_acc = 1; m_acc_at = -1; resolve(); end
      if (cyc == m_to_at) begin m_timeout = 1; m_drops++; m_to_at = -1; resolve(); end
      if (cyc == m_done_at) begin exp_done = 1; m_done_at = -1; m_idle_at = cyc + 1; end
      // The issue strobe follows any ISSUE cycle in which downstream was ready.
      exp_strobe = m_issue_open && (cyc - 1 >= m_issue_from) && (out_ready_in == 1'b1);

      if (snapshot_latch_out) begin dut_acc = 0; dut_strobes = 0; dut_latch_cyc = cyc; end
      if (pix_valid_out) dut_strobes++;
      if (result_accept_out) dut_acc++;

      chk("snapshot_latch", int'(snapshot_latch_out), int'(exp_snap));
      chk("busy", int'(busy_out), int'(m_active));
      chk("frame_time", int'(frame_time_out), int'(m_ftime));
      chk("pix_valid", int'(pix_valid_out), int'(exp_strobe));
      chk("result_accept", int'(result_accept_out), int'(exp_acc));
      chk("frame_done", int'(frame_done_out), int'(exp_done));
      chk("timeout_err", int'(timeout_err_out), int'(m_timeout));
      chk("overrun_err", int'(overrun_err_out), int'(m_overrun));
      chk("stale_cnt", int'(stale_cnt_out), m_stale);

      if (exp_done) begin
         chk("frame_accepts", dut_acc, NPIX - m_drops);
         chk("frame_strobes", dut_strobes, NPIX);
         last_len = cyc - dut_latch_cyc + 1; last_acc = dut_acc; last_strobes = dut_strobes;
      end

      if (pix_valid_out && exp_strobe) begin
         m_cur_x = m_idx % H; m_cur_y = m_idx / H;
         chk("pix_x", int'(pix_x_out), m_cur_x);
         chk("pix_y", int'(pix_y_out), m_cur_y);
         m_issue_open = 0;
         lat  = sc_random ? int'($urandom_range(13, 15)) : 14;
         drop = (m_idx == sc_drop_idx) || (sc_random && ($urandom_range(0, 7) == 0));
         if (drop) begin
            m_to_at = cyc + TO;
         end else begin
            m_echo_cyc = cyc + lat;
            m_acc_at   = m_echo_cyc + 1;
         end
         if (m_idx == sc_stale_idx) begin
            m_stale_x = 0; m_stale_y = 2; m_stale_cyc = cyc + 5;
            m_stale_inc_at = m_stale_cyc + 1;
         end else if (sc_random && ($urandom_range(0, 3) == 0)) begin
            m_stale_x = (m_cur_x + 1) % H; m_stale_y = m_cur_y;
            m_stale_cyc = cyc + int'($urandom_range(2, 10));
            m_stale_inc_at = m_stale_cyc + 1;
         end
         m_idx++;
      end

      // Engine model: drive the echo for the whole of the scheduled cycle.
      if (cyc == m_echo_cyc) begin
         eng_valid_in = 1'b1; eng_x_in = 11'(m_cur_x); eng_y_in = 10'(m_cur_y);
         m_echo_cyc = -1;
      end else if (cyc == m_stale_cyc) begin
         eng_valid_in = 1'b1; eng_x_in = 11'(m_stale_x); eng_y_in = 10'(m_stale_y);
         m_stale_cyc = -1;
      end else begin
         eng_valid_in = 1'b0;
      end
      curr_time_in = 18'($urandom());
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      observe();
   endtask

   task automatic pulse_start(input logic [17:0] t);
      frame_start_in = 1'b1;
      curr_time_in   = t;
      tick();
      frame_start_in = 1'b0;
   endtask

   task automatic wait_done(input bit rand_ready);
      int budget;
      budget = 3000;
      while (m_active && budget > 0) begin
         if (rand_ready) out_ready_in = ($urandom_range(0, 3) != 0);
         tick();
         budget--;
      end
      out_ready_in = 1'b1;
      chk("frame_completes", int'(m_active), 0);
   endtask

   task automatic wait_idx(input int k);
      int budget;
      budget = 2000;
      while (m_idx < k && budget > 0) begin
         tick();
         budget--;
      end
      chk("reached_pixel", m_idx, k);
   endtask

   initial begin
      rst_in = 1'b0; frame_start_in = 1'b0; curr_time_in = 18'd0; out_ready_in = 1'b1;
      sc_drop_idx = -1; sc_stale_idx = -1; sc_random = 0;
      dut_acc = 0; dut_strobes = 0; dut_latch_cyc = 0; last_len = 0; last_acc = 0; last_strobes = 0;
      model_reset();
      #2;
      check_reset_vals("por");
      repeat (3) tick();
      rst_in = 1'b1;
      repeat (2) tick();

      // Clean frame with known start time.
      pulse_start(18'h12345);
      chk("t1_snapshot", int'(snapshot_latch_out), 1);
      chk("t1_frame_time", int'(frame_time_out), 32'h12345);
      wait_done(0);
      chk("t1_frame_len", last_len, 206);
      chk("t1_accepts", last_acc, 12);
      chk("t1_strobes", last_strobes, 12);
      chk("t1_time_held", int'(frame_time_out), 32'h12345);
      chk("t1_busy_after", int'(busy_out), 0);

      // Downstream stall while (2,1) waits in ISSUE.
      repeat (2) tick();
      pulse_start(18'h00abc);
      wait_idx(6);
      out_ready_in = 1'b0;
      repeat (36) tick();
      out_ready_in = 1'b1;
      wait_done(0);
      chk("t2_accepts", last_acc, 12);
      chk("t2_strobes", last_strobes, 12);

      // Engine never answers (1,0).
      sc_drop_idx = 1;
      pulse_start(18'h3ffff);
      wait_done(0);
      sc_drop_idx = -1;
      chk("t3_accepts", last_acc, 11);
      chk("t3_timeout_err", int'(timeout_err_out), 1);

      // Stale echo (0,2) while (3,1) is outstanding.
      sc_stale_idx = 7;
      pulse_start(18'h00001);
      wait_done(0);
      sc_stale_idx = -1;
      chk("t4_stale_cnt", int'(stale_cnt_out), 1);
      chk("t4_accepts", last_acc, 12);

      // Start request mid-frame, then an immediate restart after DONE.
      pulse_start(18'h11111);
      wait_idx(4);
      pulse_start(18'h22222);
      chk("t5_overrun", int'(overrun_err_out), 1);
      wait_done(0);
      chk("t5_accepts", last_acc, 12);
      pulse_start(18'h33333);
      chk("t5_restart_snapshot", int'(snapshot_latch_out), 1);
      chk("t5_restart_time", int'(frame_time_out), 32'h33333);
      wait_done(0);
      chk("t5_overrun_kept", int'(overrun_err_out), 1);

      // Asynchronous reset while (2,2) is waiting.
      pulse_start(18'h0f0f0);
      wait_idx(11);
      repeat (3) tick();
      #2;
      rst_in = 1'b0;
      #1;
      check_reset_vals("async_rst");
      model_reset();
      repeat (3) tick();
      rst_in = 1'b1;
      repeat (2) tick();
      pulse_start(18'h2468a);
      wait_done(0);
      chk("t6_frame_len", last_len, 206);
      chk("t6_accepts", last_acc, 12);
      chk("t6_flags_clear", int'({timeout_err_out, overrun_err_out}), 0);
      chk("t6_stale_clear", int'(stale_cnt_out), 0);

      // Randomised frames: random engine latency, drops, stale echoes and backpressure.
      sc_random = 1;
      for (int f = 0; f < 6; f++) begin
         repeat ($urandom_range(0, 3)) tick();
         pulse_start(18'($urandom()));
         wait_done(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
